// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and types for the pipeline control slice.
// Instruction codes, status codes, condition-code bit positions, run-state enum, hazard terms.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam int CC_OF = 2;
  localparam int CC_SF = 1;
  localparam int CC_ZF = 0;
  localparam logic [2:0] CC_RESET = 3'(1 << CC_ZF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } run_state_t;

  typedef struct packed {
    logic luse;
    logic ret;
    logic mis;
    logic exc;
    logic w_exc;
  } hazard_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Pipeline hazard term decode: load-use, return-in-flight, mispredict, exceptions.
// Latency: purely combinational, same cycle.
// Backpressure: none; terms are consumed by the run-state controller.
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_destM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  input  logic [3:0] m_stat,
  input  logic [3:0] W_stat,
  output hazard_t    hz
);

  logic e_is_load;

  always_comb begin
    e_is_load = (E_icode == I_MRMOVQ) || (E_icode == I_POPQ);
    hz.luse   = e_is_load && (E_destM != R_NONE) &&
                ((E_destM == d_srcA) || (E_destM == d_srcB));
    hz.ret    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    hz.mis    = (E_icode == I_JXX) && !e_Cnd;
    hz.w_exc  = (W_stat != STAT_AOK);
    hz.exc    = (m_stat != STAT_AOK) || hz.w_exc;
  end

endmodule

// File: rtl/pipe_control.sv
// Y86-64 pipeline run-state controller: stall/bubble drive, CC register, perf counters.
// Latency: stall/bubble/setcc combinational; state, CC, final_stat and counters update on posedge.
// Backpressure: stalls F/D/W outside RUN and on hazards; counters saturate instead of wrapping.
module pipe_control
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_destM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic [2:0]       cc_in,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             setcc,
  output logic [2:0]       cc_q,
  output logic             running,
  output logic             halted,
  output logic [3:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] luse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  run_state_t state, state_nxt;
  hazard_t    hz;

  pipe_hazard_detect u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_destM (E_destM),
    .e_Cnd   (e_Cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .hz      (hz)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start)    state_nxt = ST_RUN;
      ST_RUN:    if (hz.w_exc) state_nxt = ST_HALTED;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outside RUN the pipe is frozen: front end and writeback held, no bubbles, no CC writes.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b1;
    setcc    = 1'b0;
    running  = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_RUN: begin
        F_stall  = hz.luse | hz.ret;
        D_stall  = hz.luse;
        D_bubble = hz.mis | (hz.ret & ~hz.luse);
        E_bubble = hz.mis | hz.luse;
        M_bubble = hz.exc;
        W_stall  = hz.w_exc;
        setcc    = (E_icode == I_OPQ) & ~hz.exc;
        running  = 1'b1;
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q       <= CC_RESET;
      final_stat <= STAT_AOK;
    end else begin
      if (setcc) cc_q <= cc_in;
      if ((state == ST_RUN) && (state_nxt == ST_HALTED)) final_stat <= W_stat;
    end
  end

  // A load-use stall replays the RET, so it is only counted once it actually bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      luse_cnt    <= '0;
      mispred_cnt <= '0;
      ret_cnt     <= '0;
    end else if (state == ST_RUN) begin
      cycle_cnt   <= sat_inc(cycle_cnt, 1'b1);
      luse_cnt    <= sat_inc(luse_cnt, hz.luse);
      mispred_cnt <= sat_inc(mispred_cnt, hz.mis);
      ret_cnt     <= sat_inc(ret_cnt, hz.ret & ~hz.luse);
    end
  end

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: expectations queued by stimulus, checked by a negedge monitor.
module tb_pipe_control;
  import y86_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [6:0]    ctrl;  // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,setcc}
    logic [2:0]    cc;
    logic          run;
    logic          hlt;
    logic [3:0]    fstat;
    logic [CW-1:0] cyc;
    logic [CW-1:0] lu;
    logic [CW-1:0] mi;
    logic [CW-1:0] rt;
  } obs_t;

  localparam logic [6:0] C_IDLE = 7'b1100010;
  localparam logic [6:0] C_RUN  = 7'b0000000;
  localparam logic [6:0] C_LUSE = 7'b1101000;
  localparam logic [6:0] C_MIS  = 7'b0011000;
  localparam logic [6:0] C_RET  = 7'b1010000;

  logic clk = 1'b0;
  logic reset, start, e_Cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_destM, M_icode, m_stat, W_stat;
  logic [2:0] cc_in;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc;
  logic [2:0] cc_q;
  logic running, halted;
  logic [3:0] final_stat;
  logic [CW-1:0] cycle_cnt, luse_cnt, mispred_cnt, ret_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  obs_t  exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  pipe_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_destM(E_destM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat), .cc_in(cc_in),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .setcc(setcc), .cc_q(cc_q),
    .running(running), .halted(halted), .final_stat(final_stat),
    .cycle_cnt(cycle_cnt), .luse_cnt(luse_cnt), .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
  );

  function automatic obs_t mk(input logic [6:0] c, input logic [2:0] cc, input logic r,
                              input logic h, input logic [3:0] fs, input int cy,
                              input int lu, input int mi, input int rt);
    obs_t o;
    o.ctrl = c; o.cc = cc; o.run = r; o.hlt = h; o.fstat = fs;
    o.cyc = CW'(cy); o.lu = CW'(lu); o.mi = CW'(mi); o.rt = CW'(rt);
    return o;
  endfunction

  task automatic quiet();
    reset = 1'b0; start = 1'b0;
    D_icode = I_NOP; d_srcA = R_NONE; d_srcB = R_NONE;
    E_icode = I_NOP; E_destM = R_NONE; e_Cnd = 1'b1; M_icode = I_NOP;
    m_stat = STAT_AOK; W_stat = STAT_AOK; cc_in = 3'b000;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    quiet();
  endtask

  task automatic expect_obs(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, setcc, cc_q,
            running, halted, final_stat, cycle_cnt, luse_cnt, mispred_cnt, ret_cnt};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got ctrl=%b cc=%b run=%b hlt=%b fstat=%b cyc=%0d lu=%0d mi=%0d rt=%0d, want ctrl=%b cc=%b run=%b hlt=%b fstat=%b cyc=%0d lu=%0d mi=%0d rt=%0d",
                 nm, a.ctrl, a.cc, a.run, a.hlt, a.fstat, a.cyc, a.lu, a.mi, a.rt,
                 e.ctrl, e.cc, e.run, e.hlt, e.fstat, e.cyc, e.lu, e.mi, e.rt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    quiet();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    quiet();
    expect_obs("reset_state", mk(C_IDLE, 3'b001, 0, 0, STAT_AOK, 0, 0, 0, 0));

    next_cycle(); E_icode = I_OPQ; cc_in = 3'b111;
    expect_obs("idle_no_setcc", mk(C_IDLE, 3'b001, 0, 0, STAT_AOK, 0, 0, 0, 0));

    next_cycle(); start = 1'b1;
    expect_obs("start_cycle", mk(C_IDLE, 3'b001, 0, 0, STAT_AOK, 0, 0, 0, 0));

    next_cycle();
    expect_obs("run_quiet", mk(C_RUN, 3'b001, 1, 0, STAT_AOK, 0, 0, 0, 0));

    next_cycle(); E_icode = I_MRMOVQ; E_destM = 4'd3; d_srcA = 4'd3;
    expect_obs("luse_mrmov_srcA", mk(C_LUSE, 3'b001, 1, 0, STAT_AOK, 1, 0, 0, 0));

    next_cycle(); E_icode = I_POPQ; E_destM = 4'd5; d_srcB = 4'd5;
    expect_obs("luse_pop_srcB", mk(C_LUSE, 3'b001, 1, 0, STAT_AOK, 2, 1, 0, 0));

    next_cycle(); E_icode = I_MRMOVQ;
    expect_obs("no_luse_destF", mk(C_RUN, 3'b001, 1, 0, STAT_AOK, 3, 2, 0, 0));

    next_cycle(); E_icode = I_JXX; e_Cnd = 1'b0;
    expect_obs("mispredict", mk(C_MIS, 3'b001, 1, 0, STAT_AOK, 4, 2, 0, 0));

    next_cycle(); E_icode = I_JXX; e_Cnd = 1'b1;
    expect_obs("jxx_taken", mk(C_RUN, 3'b001, 1, 0, STAT_AOK, 5, 2, 1, 0));

    next_cycle(); D_icode = I_RET;
    expect_obs("ret_in_D", mk(C_RET, 3'b001, 1, 0, STAT_AOK, 6, 2, 1, 0));

    next_cycle(); E_icode = I_RET;
    expect_obs("ret_in_E", mk(C_RET, 3'b001, 1, 0, STAT_AOK, 7, 2, 1, 1));

    next_cycle(); M_icode = I_RET;
    expect_obs("ret_in_M", mk(C_RET, 3'b001, 1, 0, STAT_AOK, 8, 2, 1, 2));

    next_cycle(); E_icode = I_MRMOVQ; E_destM = 4'd2; d_srcA = 4'd2; M_icode = I_RET;
    expect_obs("luse_and_ret", mk(C_LUSE, 3'b001, 1, 0, STAT_AOK, 9, 2, 1, 3));

    next_cycle(); E_icode = I_OPQ; cc_in = 3'b010;
    expect_obs("opq_setcc", mk(7'b0000001, 3'b001, 1, 0, STAT_AOK, 10, 3, 1, 3));

    next_cycle(); E_icode = I_OPQ; cc_in = 3'b111; m_stat = STAT_ADR;
    expect_obs("opq_m_exc", mk(7'b0000100, 3'b010, 1, 0, STAT_AOK, 11, 3, 1, 3));

    next_cycle();
    expect_obs("cc_held", mk(C_RUN, 3'b010, 1, 0, STAT_AOK, 12, 3, 1, 3));

    next_cycle(); W_stat = STAT_HLT; E_icode = I_OPQ; cc_in = 3'b101;
    expect_obs("w_halt_in_run", mk(7'b0000110, 3'b010, 1, 0, STAT_AOK, 13, 3, 1, 3));

    next_cycle(); start = 1'b1; E_icode = I_MRMOVQ; E_destM = 4'd3; d_srcA = 4'd3;
    expect_obs("halted_entry", mk(C_IDLE, 3'b010, 0, 1, STAT_HLT, 14, 3, 1, 3));

    next_cycle(); W_stat = STAT_INS; D_icode = I_RET;
    expect_obs("halted_frozen", mk(C_IDLE, 3'b010, 0, 1, STAT_HLT, 14, 3, 1, 3));

    next_cycle(); reset = 1'b1;
    expect_obs("halted_reset_cycle", mk(C_IDLE, 3'b010, 0, 1, STAT_HLT, 14, 3, 1, 3));

    next_cycle(); start = 1'b1;
    expect_obs("reset_from_halt", mk(C_IDLE, 3'b001, 0, 0, STAT_AOK, 0, 0, 0, 0));

    for (int i = 0; i < 7; i++) begin
      next_cycle();
      expect_obs("run_count", mk(C_RUN, 3'b001, 1, 0, STAT_AOK, i, 0, 0, 0));
    end

    next_cycle(); reset = 1'b1;
    expect_obs("run_cyc7_reset", mk(C_RUN, 3'b001, 1, 0, STAT_AOK, 7, 0, 0, 0));

    next_cycle(); start = 1'b1;
    expect_obs("reset_mid_run", mk(C_IDLE, 3'b001, 0, 0, STAT_AOK, 0, 0, 0, 0));

    // 4-bit counters must stick at 15 rather than wrap.
    for (int i = 0; i < 18; i++) begin
      next_cycle(); E_icode = I_POPQ; E_destM = 4'd7; d_srcB = 4'd7;
      expect_obs("saturate", mk(C_LUSE, 3'b001, 1, 0, STAT_AOK,
                                (i > 15) ? 15 : i, (i > 15) ? 15 : i, 0, 0));
    end

    next_cycle();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
